// File: rtl/piso_shift_ctrl.sv
//------------------------------------------------------------------------------
// piso_shift_ctrl
//
// Parallel-in / serial-out shifter with a ready/valid load handshake.
// A word is accepted on a rising edge where in_valid && in_ready. The frame
// is then presented one bit per cycle on Serial_Out, starting the cycle after
// the accepting edge. While the last bit of a frame is on the line, in_ready
// is high again, so a new word can follow with no gap.
//
// Parameters
//   WIDTH      data bits per word (2..32)
//   MSB_FIRST  1: Parallel_In[WIDTH-1] goes out first, 0: Parallel_In[0] first
//
// Compile-time option
//   PISO_PARITY_EN  when defined, an even-parity bit (XOR of the word) is
//                   appended after the last data bit (frame = WIDTH+1 bits).
//                   When undefined, frame = WIDTH bits and no parity logic.
//
// Ports
//   Clk          in   clock, all state updates on the rising edge
//   Rst          in   synchronous active-high reset, highest priority
//   Parallel_In  in   word to serialise, sampled only at the accepting edge
//   in_valid     in   Parallel_In holds a word to load
//   in_ready     out  a word can be accepted this cycle (combinational)
//   Serial_Out   out  registered serial data bit (0 when idle)
//   out_valid    out  Serial_Out carries a frame bit this cycle
//   busy         out  a frame is in progress
//   done         out  high while the last frame bit is on Serial_Out
//------------------------------------------------------------------------------
module piso_shift_ctrl #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [WIDTH-1:0] Parallel_In,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             Serial_Out,
    output logic             out_valid,
    output logic             busy,
    output logic             done
);

`ifdef PISO_PARITY_EN
    localparam int FRAME_LEN = WIDTH + 1;
`else
    localparam int FRAME_LEN = WIDTH;
`endif
    localparam int CNT_W = $clog2(FRAME_LEN + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t               state;
    // Bits still to be sent, next one in the MSB position.
    logic [FRAME_LEN-1:0] shift_reg;
    // Bits remaining after the one currently on Serial_Out.
    logic [CNT_W-1:0]     bit_cnt;
    logic                 accept;
    logic [FRAME_LEN-1:0] frame;

    // Arrange a word into transmit order: frame[FRAME_LEN-1] is sent first,
    // the optional parity bit lands in frame[0] and is sent last.
    function automatic logic [FRAME_LEN-1:0] build_frame(input logic [WIDTH-1:0] word);
        logic [FRAME_LEN-1:0] f;
        f = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (MSB_FIRST != 0) begin
                f[FRAME_LEN-1-i] = word[WIDTH-1-i];
            end else begin
                f[FRAME_LEN-1-i] = word[i];
            end
        end
`ifdef PISO_PARITY_EN
        f[0] = ^word;
`endif
        return f;
    endfunction

    // done is registered and only ever set in SHIFT on the last bit, so it
    // doubles as the "last bit on the line" qualifier for the handshake.
    assign in_ready = (state == IDLE) || done;
    assign accept   = in_valid && in_ready;
    assign frame    = build_frame(Parallel_In);

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state      <= IDLE;
            shift_reg  <= '0;
            bit_cnt    <= '0;
            Serial_Out <= 1'b0;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else if (accept) begin
            // Load: first bit goes straight to the output register, the rest
            // wait in shift_reg. Covers both IDLE and back-to-back reloads.
            state      <= SHIFT;
            Serial_Out <= frame[FRAME_LEN-1];
            shift_reg  <= frame << 1;
            bit_cnt    <= CNT_W'(FRAME_LEN - 1);
            out_valid  <= 1'b1;
            busy       <= 1'b1;
            done       <= 1'b0;
        end else if (state == SHIFT) begin
            if (done) begin
                // Last bit has been shown and nothing new arrived.
                state      <= IDLE;
                shift_reg  <= '0;
                bit_cnt    <= '0;
                Serial_Out <= 1'b0;
                out_valid  <= 1'b0;
                busy       <= 1'b0;
                done       <= 1'b0;
            end else begin
                Serial_Out <= shift_reg[FRAME_LEN-1];
                shift_reg  <= shift_reg << 1;
                bit_cnt    <= bit_cnt - 1'b1;
                done       <= (bit_cnt == CNT_W'(1));
            end
        end
    end

endmodule
